// File: rtl/switch_pkg.sv
// Shared types and helpers for the packet switch ingress ports.
// The packet classifier lives here so that every port variant applies the same rules.
package switch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ROUTE    = 2'b01,
        ARB_WAIT = 2'b10,
        TRANSMIT = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ERR = 2'b00,
        SDP = 2'b01,
        MDP = 2'b10,
        BDP = 2'b11
    } p_type_e;

    localparam int MAX_PORTS = 32;

    // Masks are zero-extended to MAX_PORTS so one function serves any port count.
    function automatic p_type_e classify(input logic [MAX_PORTS-1:0] src,
                                         input logic [MAX_PORTS-1:0] tgt,
                                         input int port_id,
                                         input int num_ports);
        logic [MAX_PORTS-1:0] self_bit;
        logic [MAX_PORTS-1:0] others;
        int ones;
        self_bit = '0;
        others   = '0;
        ones     = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (i == port_id) self_bit[i] = 1'b1;
            if (i < num_ports && i != port_id) others[i] = 1'b1;
            if (tgt[i]) ones = ones + 1;
        end
        if (src != self_bit || tgt == '0 || (tgt & self_bit) != '0) return ERR;
        if (tgt == others) return BDP;
        if (ones == 1) return SDP;
        return MDP;
    endfunction

endpackage

// File: rtl/switch_fifo.sv
// First-word-fall-through FIFO with full/empty/count, shared by the switch ports.
// Push when full and pop when empty are ignored so callers cannot corrupt the pointers.
module switch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/switch_port_mc.sv
// Ingress port: buffers packets, classifies the head, drops errors and replicates
// multicast packets over successive crossbar grants until served or timed out.
module switch_port_mc
    import switch_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int PORT_ID     = 0,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 8,
    parameter int ARB_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [NUM_PORTS-1:0] source_in,
    input  logic [NUM_PORTS-1:0] target_in,
    input  logic [DATA_W-1:0]    data_in,
    output logic                 in_ready,
    output logic [NUM_PORTS-1:0] req_out,
    input  logic [NUM_PORTS-1:0] grant_in,
    output logic                 valid_out,
    output logic [NUM_PORTS-1:0] source_out,
    output logic [NUM_PORTS-1:0] target_out,
    output logic [DATA_W-1:0]    data_out,
    output logic [7:0]           drop_cnt,
    output logic                 busy
);
    localparam int PKT_W = 2 * NUM_PORTS + DATA_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TO_W  = (ARB_TIMEOUT > 1) ? $clog2(ARB_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((ARB_TIMEOUT > 0) ? ARB_TIMEOUT - 1 : 0);

    state_e               state, next_state;
    logic [PKT_W-1:0]     head;
    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 push, pop, overflow, fsm_drop, timeout_hit;
    logic [NUM_PORTS-1:0] head_src, head_tgt, grant_hit;
    logic [DATA_W-1:0]    head_data;
    p_type_e              head_type;
    logic [NUM_PORTS-1:0] src_q, pending, served;
    logic [DATA_W-1:0]    data_q;
    logic [TO_W-1:0]      to_cnt;
    logic [8:0]           drop_sum;

    assign in_ready = (fifo_count != CNT_W'(DEPTH));
    assign push     = valid_in & in_ready;
    assign overflow = valid_in & fifo_full;

    switch_fifo #(.WIDTH(PKT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({source_in, target_in, data_in}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {head_src, head_tgt, head_data} = head;
    assign head_type   = classify(MAX_PORTS'(head_src), MAX_PORTS'(head_tgt), PORT_ID, NUM_PORTS);
    assign grant_hit   = grant_in & pending;
    assign timeout_hit = (ARB_TIMEOUT != 0) && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // A grant seen on the final timeout cycle takes priority over abandoning the packet.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        fsm_drop   = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) next_state = ROUTE;
            ROUTE: begin
                pop = 1'b1;
                if (head_type == ERR) begin
                    fsm_drop   = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (grant_hit != '0) begin
                    next_state = TRANSMIT;
                end else if (timeout_hit) begin
                    fsm_drop   = 1'b1;
                    next_state = IDLE;
                end
            end
            TRANSMIT: next_state = ((pending & ~served) == '0) ? IDLE : ARB_WAIT;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            data_q  <= '0;
            pending <= '0;
            served  <= '0;
            to_cnt  <= '0;
        end else begin
            case (state)
                ROUTE: begin
                    src_q   <= head_src;
                    data_q  <= head_data;
                    pending <= (head_type == ERR) ? '0 : head_tgt;
                    to_cnt  <= '0;
                end
                ARB_WAIT: begin
                    if (grant_hit != '0)         served  <= grant_hit;
                    else if (timeout_hit)        pending <= '0;
                    else if (ARB_TIMEOUT != 0)   to_cnt  <= to_cnt + TO_W'(1);
                end
                TRANSMIT: begin
                    pending <= pending & ~served;
                    to_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    // An overflow and an FSM drop can coincide, so the counter may step by two.
    assign drop_sum = {1'b0, drop_cnt} + 9'(overflow) + 9'(fsm_drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    assign busy       = (state != IDLE);
    assign valid_out  = (state == TRANSMIT);
    assign req_out    = (state == ARB_WAIT) ? pending : '0;
    assign source_out = valid_out ? src_q  : '0;
    assign target_out = valid_out ? served : '0;
    assign data_out   = valid_out ? data_q : '0;

endmodule
